instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 182 ++++++++++++++++++
 tb/tb_instruction_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   Fetches a 3-byte instruction from a byte-wide program memory, one byte at
//   a time. Each byte is read with a single-cycle strobe, and the fetch then
//   waits for the memory's response strobe. The byte is forwarded to the
//   instruction register with a one-cycle load strobe. After the third byte
//   the fetcher holds until the consumer signals that the instruction is done.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous active-low reset
//   fetch_en   in   1       permits starting a new 3-byte fetch
//   mem_rd     out  1       one-cycle read strobe to program memory
//   mem_addr   out  ADDR_W  byte address (valid while mem_rd=1)
//   mem_data   in   8       returned byte (valid while mem_valid=1)
//   mem_valid  in   1       memory response strobe
//   payload    out  8       byte forwarded to the instruction register
//   IR_load    out  1       one-cycle strobe, payload valid in same cycle
//   inst_done  in   1       downstream consumed the assembled instruction
//   pc_load    in   1       overwrite PC (honoured in IDLE/HOLD only)
//   pc_in      in   ADDR_W  new PC value
//   pc         out  ADDR_W  current program counter
//   busy       out  1       high in REQ, WAIT and PUSH
//   fetch_done out  1       one-cycle pulse when the third byte is pushed
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int                   ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  input  logic              mem_valid,
  output logic [7:0]        payload,
  output logic              IR_load,
  input  logic              inst_done,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              fetch_done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_byte_cnt;
  logic [1:0]          w_byte_cnt_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [7:0]          r_payload;
  logic [7:0]          w_payload_nxt;
  logic                r_mem_rd;
  logic                r_ir_load;
  logic                r_fetch_done;
  logic                r_busy;
  logic                w_pc_writable;

  // PC may only be overwritten while no fetch is in flight.
  assign w_pc_writable = (r_state == S_IDLE) || (r_state == S_HOLD);

  // Next-state decode of the fetch sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (fetch_en) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid) begin
          w_state_nxt = S_PUSH;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_PUSH: begin
        if (r_byte_cnt == 2'd2) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_HOLD: begin
        if (inst_done && fetch_en) begin
          w_state_nxt = S_REQ;
        end else if (inst_done) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath next values: PC, byte counter and captured payload byte.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_byte_cnt_nxt = r_byte_cnt;
    w_payload_nxt  = r_payload;

    // PUSH advances the PC (natural wrap modulo 2^ADDR_W); a load is only
    // possible outside a fetch, so the two never collide.
    if (r_state == S_PUSH) begin
      w_pc_nxt = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else if (w_pc_writable && pc_load) begin
      w_pc_nxt = pc_in;
    end else begin
      w_pc_nxt = r_pc;
    end

    // A fresh fetch starting from IDLE/HOLD always begins at byte 0.
    if (r_state == S_PUSH) begin
      w_byte_cnt_nxt = r_byte_cnt + 2'd1;
    end else if (w_pc_writable && (w_state_nxt == S_REQ)) begin
      w_byte_cnt_nxt = 2'd0;
    end else begin
      w_byte_cnt_nxt = r_byte_cnt;
    end

    if ((r_state == S_WAIT) && mem_valid) begin
      w_payload_nxt = mem_data;
    end else begin
      w_payload_nxt = r_payload;
    end
  end

  // State, datapath and registered strobes; strobes are decoded from the
  // next state so each one lines up exactly with its state's cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_byte_cnt   <= 2'd0;
      r_payload    <= 8'h00;
      r_mem_rd     <= 1'b0;
      r_ir_load    <= 1'b0;
      r_fetch_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_payload    <= w_payload_nxt;
      r_mem_rd     <= (w_state_nxt == S_REQ);
      r_ir_load    <= (w_state_nxt == S_PUSH);
      // Counter is unchanged between WAIT and PUSH, so it still names the
      // byte about to be pushed.
      r_fetch_done <= (w_state_nxt == S_PUSH) && (r_byte_cnt == 2'd2);
      r_busy       <= (w_state_nxt == S_REQ) || (w_state_nxt == S_WAIT) ||
                      (w_state_nxt == S_PUSH);
    end
  end

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_pc;
  assign payload    = r_payload;
  assign IR_load    = r_ir_load;
  assign pc         = r_pc;
  assign busy       = r_busy;
  assign fetch_done = r_fetch_done;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fetch_en;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic [7:0] payload;
  logic       IR_load;
  logic       inst_done;
  logic       pc_load;
  logic [7:0] pc_in;
  logic [7:0] pc;
  logic       busy;
  logic       fetch_done;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_valid(mem_valid),
    .payload(payload), .IR_load(IR_load), .inst_done(inst_done),
    .pc_load(pc_load), .pc_in(pc_in), .pc(pc), .busy(busy),
    .fetch_done(fetch_done)
  );

  always #5 clk = ~clk;

  // Program memory model with configurable response latency (in cycles after
  // the mem_rd cycle; 1 means mem_valid in the first WAIT cycle).
  logic [7:0] mem [256];
  int         lat = 1;
  logic       pend = 1'b0;
  int         rem = 0;
  logic [7:0] raddr = 8'h00;

  initial begin
    mem_valid = 1'b0;
    mem_data  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  end

  always begin
    logic       rd_seen;
    logic [7:0] a_seen;
    @(posedge clk);
    rd_seen = mem_rd;
    a_seen  = mem_addr;
    #1;
    mem_valid = 1'b0;
    if (rd_seen) begin
      if (lat == 1) begin
        mem_valid = 1'b1;
        mem_data  = mem[a_seen];
      end else begin
        pend  = 1'b1;
        rem   = lat - 1;
        raddr = a_seen;
      end
    end else if (pend) begin
      if (rem == 1) begin
        mem_valid = 1'b1;
        mem_data  = mem[raddr];
        pend      = 1'b0;
      end else begin
        rem = rem - 1;
      end
    end
  end

  // Monitor: record pushed bytes, read addresses and done pulses.
  logic [7:0] pay_q[$];
  logic [7:0] addr_q[$];
  int         fd_cnt = 0;

  always @(negedge clk) begin
    if (IR_load)    pay_q.push_back(payload);
    if (mem_rd)     addr_q.push_back(mem_addr);
    if (fetch_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk);
    pay_q.delete();
    addr_q.delete();
    fd_cnt = 0;
  endtask

  // Waits for fetch_done; reports cycles from first mem_rd (inclusive) and
  // whether busy dropped anywhere inside that window.
  task automatic run_fetch(input int budget, output logic done, output int cyc,
                           output int busy_low, output logic ir_with_fd);
    logic started;
    done = 1'b0; cyc = 0; busy_low = 0; started = 1'b0; ir_with_fd = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (mem_rd) started = 1'b1;
      if (started) begin
        cyc++;
        if (!busy) busy_low++;
      end
      if (fetch_done) begin
        done = 1'b1;
        ir_with_fd = IR_load;
      end
    end
  endtask

  initial begin
    logic done;
    logic irfd;
    int   cyc;
    int   blow;
    int   cnt;

    rst_n = 1'b0; fetch_en = 1'b0; inst_done = 1'b0; pc_load = 1'b0; pc_in = 8'h00;
    mem[8'h00] = 8'hA1; mem[8'h01] = 8'hB2; mem[8'h02] = 8'hC3;
    mem[8'h03] = 8'h11; mem[8'h04] = 8'h22; mem[8'h05] = 8'h33;
    mem[8'hFE] = 8'h5A; mem[8'hFF] = 8'h6B;
    mem[8'h40] = 8'h44; mem[8'h41] = 8'h55; mem[8'h42] = 8'h66;
    mem[8'h43] = 8'h77; mem[8'h44] = 8'h88;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_ir_load", {31'd0, IR_load}, 32'd0);
    chk("rst_fetch_done", {31'd0, fetch_done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'h00);
    chk("rst_payload", {24'd0, payload}, 32'h00);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    rst_n = 1'b1;

    // Basic fetch, 1-cycle latency
    lat = 1;
    clear_mon();
    fetch_en = 1'b1;
    run_fetch(60, done, cyc, blow, irfd);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_latency", cyc, 32'd9);
    chk("t1_ir_with_fd", {31'd0, irfd}, 32'd1);
    @(negedge clk);
    chk("t1_n_ir", pay_q.size(), 32'd3);
    chk("t1_b0", {24'd0, pay_q[0]}, 32'hA1);
    chk("t1_b1", {24'd0, pay_q[1]}, 32'hB2);
    chk("t1_b2", {24'd0, pay_q[2]}, 32'hC3);
    chk("t1_n_fd", fd_cnt, 32'd1);
    chk("t1_pc", {24'd0, pc}, 32'h03);
    chk("t1_hold_busy", {31'd0, busy}, 32'd0);
    chk("t1_payload_hold", {24'd0, payload}, 32'hC3);
    // Stay in HOLD without inst_done: no new read
    repeat (3) @(negedge clk);
    chk("t1_hold_no_rd", addr_q.size(), 32'd3);
    fetch_en = 1'b0; inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;

    // Slow memory, 5-cycle latency
    lat = 5;
    clear_mon();
    fetch_en = 1'b1;
    run_fetch(120, done, cyc, blow, irfd);
    fetch_en = 1'b0;
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_latency", cyc, 32'd21);
    chk("t2_busy_low", blow, 32'd0);
    @(negedge clk);
    chk("t2_n_rd", addr_q.size(), 32'd3);
    chk("t2_n_ir", pay_q.size(), 32'd3);
    chk("t2_bytes", {8'd0, pay_q[0], pay_q[1], pay_q[2]}, 32'h00112233);
    chk("t2_pc", {24'd0, pc}, 32'h06);
    inst_done = 1'b1;
    @(negedge clk);
    inst_done = 1'b0;

    // PC wrap: load 0xFE in IDLE
    lat = 1;
    pc_load = 1'b1; pc_in = 8'hFE;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t3_pc_load_idle", {24'd0, pc}, 32'hFE);
    clear_mon();
    fetch_en = 1'b1;
    run_fetch(60, done, cyc, blow, irfd);
    fetch_en = 1'b0;
    chk("t3_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("t3_addrs", {8'd0, addr_q[0], addr_q[1], addr_q[2]}, 32'h00FEFF00);
    chk("t3_bytes", {8'd0, pay_q[0], pay_q[1], pay_q[2]}, 32'h005A6BA1);
    chk("t3_pc", {24'd0, pc}, 32'h01);

    // pc_load together with inst_done in HOLD, then pc_load during WAIT
    lat = 3;
    clear_mon();
    pc_load = 1'b1; pc_in = 8'h40; inst_done = 1'b1; fetch_en = 1'b1;
    @(negedge clk);
    pc_load = 1'b0; inst_done = 1'b0;
    chk("t4_first_rd", {31'd0, mem_rd}, 32'd1);
    chk("t4_addr", {24'd0, mem_addr}, 32'h40);
    @(negedge clk);
    fetch_en = 1'b0;
    pc_load = 1'b1; pc_in = 8'h77;
    @(negedge clk);
    pc_load = 1'b0;
    chk("t5_pc_wait_ignored", {24'd0, pc}, 32'h40);
    run_fetch(80, done, cyc, blow, irfd);
    chk("t5_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("t5_bytes", {8'd0, pay_q[0], pay_q[1], pay_q[2]}, 32'h00445566);
    chk("t5_pc", {24'd0, pc}, 32'h43);

    // Reset in WAIT after byte 2 has been requested
    lat = 5;
    clear_mon();
    inst_done = 1'b1; fetch_en = 1'b1;
    @(negedge clk);
    inst_done = 1'b0; fetch_en = 1'b0;
    cnt = 0;
    while (addr_q.size() < 2 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    chk("t6_reached_byte2", addr_q.size(), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_rst_outs", {25'd0, mem_rd, IR_load, fetch_done, busy, 3'd0}, 32'd0);
    chk("t6_rst_pc", {24'd0, pc}, 32'h00);
    chk("t6_rst_payload", {24'd0, payload}, 32'h00);
    chk("t6_rst_mem_addr", {24'd0, mem_addr}, 32'h00);
    pay_q.delete(); fd_cnt = 0;
    repeat (8) @(negedge clk);
    chk("t6_no_ir_after_rst", pay_q.size(), 32'd0);
    chk("t6_no_fd_after_rst", fd_cnt, 32'd0);

    // Fresh fetch after reset starts at RESET_PC
    lat = 1;
    clear_mon();
    fetch_en = 1'b1;
    run_fetch(60, done, cyc, blow, irfd);
    fetch_en = 1'b0;
    chk("t7_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("t7_first_addr", {24'd0, addr_q[0]}, 32'h00);
    chk("t7_bytes", {8'd0, pay_q[0], pay_q[1], pay_q[2]}, 32'h00A1B2C3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
